ble_motor_ctrl_mc: RTL and testbench

- Multi-channel controller for BLE-series brushless motor drivers.
- Each channel maps run, direction and manual-reset requests onto the driver's FWD/REV/STOP-MODE/M0/M1/ALARM-RESET pins.
- Each channel enforces a dead time on direction reversal, filters the driver alarm, retries alarm reset automatically up to a limit, then latches a fault.
- Sits between the command/register layer and the driver pins, one instance per motor group.

---
 rtl/ble_motor_ctrl_mc.sv | 196 +++++++++++++++++++
 tb/tb_ble_motor_ctrl_mc.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_motor_ctrl_mc.sv
// Per-channel controller for BLE-series brushless drivers: run/direction pin mapping,
// reversal dead time, filtered alarm with bounded automatic reset retries and lockout.
//
// state | meaning
// IDLE  | drives off, waiting for a run request
// RUN   | driving fwd or rev from the latched direction
// DEAD  | both drives off while a direction reversal settles
// ALARM | qualified alarm seen; choose retry or lockout next cycle
// ARST  | alarm_reset pulse to the driver, filter held cleared
// LOCK  | retries exhausted, fault held until a manual reset
module ble_motor_ctrl_mc #(
    parameter int N_CH           = 2,
    parameter int CNT_W          = 32,
    parameter int DEAD_CYC       = 100000,
    parameter int ALARM_FILT_CYC = 2000,
    parameter int ARST_PULSE_CYC = 20000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_CH-1:0]   motor_state,
    input  logic [N_CH-1:0]   motor_direction,
    input  logic [N_CH-1:0]   motor_alarm_reset,
    input  logic [2*N_CH-1:0] speed_sel,
    input  logic [N_CH-1:0]   alarm_out_n,
    input  logic [N_CH-1:0]   speed_out,
    output logic [N_CH-1:0]   fwd,
    output logic [N_CH-1:0]   rev,
    output logic [N_CH-1:0]   stop_mode,
    output logic [N_CH-1:0]   m0,
    output logic [N_CH-1:0]   m1,
    output logic [N_CH-1:0]   alarm_reset,
    output logic [N_CH-1:0]   fault
);
    localparam int FILT_W = $clog2(ALARM_FILT_CYC + 1);
    localparam int RTR_W  = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DEAD  = 3'd2;
    localparam logic [2:0] S_ALARM = 3'd3;
    localparam logic [2:0] S_ARST  = 3'd4;
    localparam logic [2:0] S_LOCK  = 3'd5;

    // Timers count down to zero, so the load value is the phase length minus one.
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] ARST_LOAD = CNT_W'(ARST_PULSE_CYC - 1);

    logic unused_speed;
    assign unused_speed = ^speed_out;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic              al_meta_q, al_meta_d, al_s_q, al_s_d;
        logic [FILT_W-1:0] filt_q, filt_d;
        logic [2:0]        state_q, state_d;
        logic              dir_q, dir_d;
        logic [CNT_W-1:0]  tmr_q, tmr_d;
        logic [RTR_W-1:0]  retry_q, retry_d;
        logic              fwd_q, fwd_d, rev_q, rev_d, stop_q, stop_d;
        logic              arst_q, arst_d, fault_q, fault_d, m0_q, m0_d, m1_q, m1_d;
        logic              qualified, active;

        assign qualified = (filt_q == FILT_W'(ALARM_FILT_CYC));
        assign active    = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DEAD);

        always_comb begin
            filt_d = filt_q;
            if (al_s_q || (state_q == S_ARST)) begin
                filt_d = '0;
            end else if (!qualified) begin
                filt_d = filt_q + FILT_W'(1);
            end
        end

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            tmr_d   = tmr_q;
            retry_d = retry_q;
            if (active && qualified) begin
                state_d = S_ALARM;
            end else if (active && motor_alarm_reset[c]) begin
                state_d = S_ARST;
                retry_d = '0;
                tmr_d   = ARST_LOAD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (motor_state[c]) begin
                            state_d = S_RUN;
                            dir_d   = motor_direction[c];
                        end
                    end
                    S_RUN: begin
                        if (!motor_state[c]) begin
                            state_d = S_IDLE;
                        end else if (motor_direction[c] != dir_q) begin
                            state_d = S_DEAD;
                            tmr_d   = DEAD_LOAD;
                        end
                    end
                    S_DEAD: begin
                        if (!motor_state[c]) begin
                            state_d = S_IDLE;
                        end else if (tmr_q == '0) begin
                            state_d = S_RUN;
                            dir_d   = motor_direction[c];
                        end else begin
                            tmr_d = tmr_q - CNT_W'(1);
                        end
                    end
                    S_ALARM: begin
                        if (retry_q < RTR_W'(MAX_RETRY)) begin
                            state_d = S_ARST;
                            retry_d = retry_q + RTR_W'(1);
                            tmr_d   = ARST_LOAD;
                        end else begin
                            state_d = S_LOCK;
                        end
                    end
                    S_ARST: begin
                        if (tmr_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            tmr_d = tmr_q - CNT_W'(1);
                        end
                    end
                    S_LOCK: begin
                        if (motor_alarm_reset[c]) begin
                            state_d = S_ARST;
                            retry_d = '0;
                            tmr_d   = ARST_LOAD;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Pins are decoded from the next state so they change on the same edge as the FSM.
        always_comb begin
            al_meta_d = alarm_out_n[c];
            al_s_d    = al_meta_q;
            fwd_d     = (state_d == S_RUN) && dir_d;
            rev_d     = (state_d == S_RUN) && !dir_d;
            stop_d    = (state_d == S_ALARM) || (state_d == S_ARST) || (state_d == S_LOCK);
            arst_d    = (state_d == S_ARST);
            fault_d   = (state_d == S_LOCK);
            m0_d      = speed_sel[2*c];
            m1_d      = speed_sel[2*c+1];
        end

        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst) begin
                al_meta_q <= 1'b0;
                al_s_q    <= 1'b0;
                filt_q    <= '0;
                state_q   <= S_IDLE;
                dir_q     <= 1'b0;
                tmr_q     <= '0;
                retry_q   <= '0;
                fwd_q     <= 1'b0;
                rev_q     <= 1'b0;
                stop_q    <= 1'b0;
                arst_q    <= 1'b0;
                fault_q   <= 1'b0;
                m0_q      <= 1'b0;
                m1_q      <= 1'b0;
            end else begin
                al_meta_q <= al_meta_d;
                al_s_q    <= al_s_d;
                filt_q    <= filt_d;
                state_q   <= state_d;
                dir_q     <= dir_d;
                tmr_q     <= tmr_d;
                retry_q   <= retry_d;
                fwd_q     <= fwd_d;
                rev_q     <= rev_d;
                stop_q    <= stop_d;
                arst_q    <= arst_d;
                fault_q   <= fault_d;
                m0_q      <= m0_d;
                m1_q      <= m1_d;
            end
        end

        assign fwd[c]         = fwd_q;
        assign rev[c]         = rev_q;
        assign stop_mode[c]   = stop_q;
        assign alarm_reset[c] = arst_q;
        assign fault[c]       = fault_q;
        assign m0[c]          = m0_q;
        assign m1[c]          = m1_q;
    end

endmodule

// File: tb/tb_ble_motor_ctrl_mc.sv
// Bench for ble_motor_ctrl_mc: directed stimulus, per-cycle comparison against a
// cycle-count based behavioural model, plus literal timing/count expectations.
module tb_ble_motor_ctrl_mc;
    localparam int N_CH      = 2;
    localparam int DEAD_CYC  = 8;
    localparam int FILT_CYC  = 4;
    localparam int PULSE_CYC = 6;
    localparam int MAX_RETRY = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] motor_state, motor_direction, motor_alarm_reset, alarm_out_n, speed_out;
    logic [3:0] speed_sel;
    logic [1:0] fwd, rev, stop_mode, m0, m1, alarm_reset, fault;

    ble_motor_ctrl_mc #(
        .N_CH(N_CH), .CNT_W(32), .DEAD_CYC(DEAD_CYC), .ALARM_FILT_CYC(FILT_CYC),
        .ARST_PULSE_CYC(PULSE_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .motor_state(motor_state),
        .motor_direction(motor_direction), .motor_alarm_reset(motor_alarm_reset),
        .speed_sel(speed_sel), .alarm_out_n(alarm_out_n), .speed_out(speed_out),
        .fwd(fwd), .rev(rev), .stop_mode(stop_mode), .m0(m0), .m1(m1),
        .alarm_reset(alarm_reset), .fault(fault)
    );

    always #5 sys_clk = ~sys_clk;

    typedef enum int {M_IDLE, M_RUN, M_DEAD, M_ALARM, M_ARST, M_LOCK} mode_t;

    mode_t mode    [2];
    int    since   [2];
    int    retries [2];
    int    low_run [2];
    bit    dirm    [2];
    bit    s1      [2];
    bit    s2      [2];
    logic [1:0] e_fwd, e_rev, e_stop, e_arst, e_fault, e_m0, e_m1;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b, expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model: modes with entry timestamps; phases end by elapsed cycle count.
    task automatic model_step();
        mode_t nm;
        bit    qual;
        bit    act_m;
        cyc++;
        for (int c = 0; c < N_CH; c++) begin
            if (!sys_rst) begin
                mode[c] = M_IDLE; since[c] = cyc; retries[c] = 0; low_run[c] = 0;
                dirm[c] = 1'b0; s1[c] = 1'b0; s2[c] = 1'b0;
                e_m0[c] = 1'b0; e_m1[c] = 1'b0;
            end else begin
                qual  = (low_run[c] >= FILT_CYC);
                act_m = mode[c] inside {M_IDLE, M_RUN, M_DEAD};
                nm    = mode[c];
                if (act_m && qual) begin
                    nm = M_ALARM;
                end else if (act_m && motor_alarm_reset[c]) begin
                    nm = M_ARST; retries[c] = 0;
                end else begin
                    case (mode[c])
                        M_IDLE:  if (motor_state[c]) begin nm = M_RUN; dirm[c] = motor_direction[c]; end
                        M_RUN:   if (!motor_state[c]) nm = M_IDLE;
                                 else if (motor_direction[c] != dirm[c]) nm = M_DEAD;
                        M_DEAD:  if (!motor_state[c]) nm = M_IDLE;
                                 else if (cyc - since[c] == DEAD_CYC) begin
                                     nm = M_RUN; dirm[c] = motor_direction[c];
                                 end
                        M_ALARM: if (retries[c] < MAX_RETRY) begin retries[c]++; nm = M_ARST; end
                                 else nm = M_LOCK;
                        M_ARST:  if (cyc - since[c] == PULSE_CYC) nm = M_IDLE;
                        M_LOCK:  if (motor_alarm_reset[c]) begin nm = M_ARST; retries[c] = 0; end
                        default: nm = M_IDLE;
                    endcase
                end
                if (s2[c] || mode[c] == M_ARST) low_run[c] = 0;
                else low_run[c]++;
                s2[c] = s1[c];
                s1[c] = alarm_out_n[c];
                if (nm != mode[c]) since[c] = cyc;
                mode[c] = nm;
                e_m0[c] = speed_sel[2*c];
                e_m1[c] = speed_sel[2*c+1];
            end
            e_fwd[c]   = (mode[c] == M_RUN) && dirm[c];
            e_rev[c]   = (mode[c] == M_RUN) && !dirm[c];
            e_stop[c]  = mode[c] inside {M_ALARM, M_ARST, M_LOCK};
            e_arst[c]  = (mode[c] == M_ARST);
            e_fault[c] = (mode[c] == M_LOCK);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #2;
        chk2("fwd", fwd, e_fwd);
        chk2("rev", rev, e_rev);
        chk2("stop_mode", stop_mode, e_stop);
        chk2("alarm_reset", alarm_reset, e_arst);
        chk2("fault", fault, e_fault);
        chk2("m0", m0, e_m0);
        chk2("m1", m1, e_m1);
        @(negedge sys_clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_window(input int n, input int ch, output int pulses, output int ch1_bad);
        logic prev;
        pulses  = 0;
        ch1_bad = 0;
        prev    = alarm_reset[ch];
        for (int i = 0; i < n; i++) begin
            tick();
            if (alarm_reset[ch] && !prev) pulses++;
            prev = alarm_reset[ch];
            if (rev[1] !== 1'b1) ch1_bad++;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk2({nm, "_fwd"}, fwd, 2'b00);
        chk2({nm, "_rev"}, rev, 2'b00);
        chk2({nm, "_stop"}, stop_mode, 2'b00);
        chk2({nm, "_arst"}, alarm_reset, 2'b00);
        chk2({nm, "_fault"}, fault, 2'b00);
        chk2({nm, "_m0"}, m0, 2'b00);
        chk2({nm, "_m1"}, m1, 2'b00);
    endtask

    initial begin
        int p, bad, n, first_stop, first_ar, ar_len;
        sys_rst = 1'b0; motor_state = '0; motor_direction = '0; motor_alarm_reset = '0;
        alarm_out_n = 2'b11; speed_out = '0; speed_sel = '0;
        ticks(3);
        chk_all_zero("reset");
        sys_rst = 1'b1;
        tick();

        // 1: ch0 forward, ch1 idle, speed select lag
        motor_state[0] = 1'b1; motor_direction[0] = 1'b1; speed_sel = 4'b0010;
        chk2("m1_before", m1, 2'b00);
        tick();
        chk2("t1_fwd", fwd, 2'b01);
        chk2("t1_rev", rev, 2'b00);
        chk2("t1_m1", m1, 2'b01);
        chk2("t1_m0", m0, 2'b00);
        chk2("t1_stop", stop_mode, 2'b00);
        speed_sel = 4'b1101;
        tick();
        chk2("t1_m0b", m0, 2'b11);
        chk2("t1_m1b", m1, 2'b10);
        motor_state[1] = 1'b1; motor_direction[1] = 1'b0;
        tick();
        chk2("ch1_rev", rev, 2'b10);

        // 2: reversal dead time
        motor_direction[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rev[0]) break;
            n++;
        end
        chki("dead_len_rev", n, DEAD_CYC);
        chki("dead_end_rev", int'(rev[0]), 1);
        motor_direction[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fwd[0]) break;
            n++;
            if (n == 3) motor_direction[0] = 1'b0;
            if (n == 5) motor_direction[0] = 1'b1;
        end
        chki("dead_len_toggle", n, DEAD_CYC);
        motor_state[0] = 1'b0; motor_direction[0] = 1'b0;
        tick();
        chk2("stop_no_dead", {fwd[0], rev[0]}, 2'b00);
        ticks(3);
        motor_state[0] = 1'b1;
        tick();
        chki("restart_rev", int'(rev[0]), 1);
        motor_direction[0] = 1'b1;
        ticks(2);
        motor_state[0] = 1'b0;
        tick();
        motor_state[0] = 1'b1;
        tick();
        chki("dead_abort_fwd", int'(fwd[0]), 1);

        // held manual reset on ch1 re-enters ARST after each pulse
        motor_alarm_reset[1] = 1'b1;
        p = 0;
        for (int i = 1; i <= 25; i++) begin
            logic prev1;
            prev1 = alarm_reset[1];
            if (i == 17) motor_alarm_reset[1] = 1'b0;
            tick();
            if (alarm_reset[1] && !prev1) p++;
        end
        chki("held_mar_pulses", p, 3);
        chki("ch1_back_rev", int'(rev[1]), 1);

        // 3: short glitch ignored, long alarm gives one pulse
        alarm_out_n[0] = 1'b0;
        ticks(3);
        alarm_out_n[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (stop_mode[0] || alarm_reset[0]) n++;
        end
        chki("glitch_ignored", n, 0);
        alarm_out_n[0] = 1'b0;
        first_stop = 0; first_ar = 0; ar_len = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) alarm_out_n[0] = 1'b1;
            tick();
            if (stop_mode[0] && first_stop == 0) first_stop = i;
            if (alarm_reset[0]) begin
                if (first_ar == 0) first_ar = i;
                ar_len++;
            end
        end
        chki("alarm_stop_at", first_stop, 7);
        chki("alarm_pulse_at", first_ar, 8);
        chki("alarm_pulse_len", ar_len, PULSE_CYC);
        chki("after_alarm_fwd", int'(fwd[0]), 1);

        // 4: manual reset clears retries, then persistent alarm locks out
        motor_alarm_reset[0] = 1'b1;
        tick();
        chki("manual_arst", int'(alarm_reset[0]), 1);
        motor_alarm_reset[0] = 1'b0;
        ticks(8);
        alarm_out_n[0] = 1'b0;
        run_window(60, 0, p, bad);
        chki("retry_pulses", p, MAX_RETRY);
        chki("lock_fault", int'(fault[0]), 1);
        chki("lock_stop", int'(stop_mode[0]), 1);
        chki("ch1_unaffected", bad, 0);

        // 5: clear lockout, retries available again
        motor_alarm_reset[0] = 1'b1;
        tick();
        motor_alarm_reset[0] = 1'b0;
        chki("clear_fault", int'(fault[0]), 0);
        chki("clear_pulse", int'(alarm_reset[0]), 1);
        run_window(59, 0, p, bad);
        chki("retry_again", p, MAX_RETRY);
        chki("relock_fault", int'(fault[0]), 1);

        // 6: async reset mid-ARST and mid-DEAD
        motor_alarm_reset[0] = 1'b1;
        tick();
        motor_alarm_reset[0] = 1'b0;
        ticks(2);
        sys_rst = 1'b0;
        #1;
        chk_all_zero("rst_arst");
        ticks(2);
        alarm_out_n[0] = 1'b1; motor_direction[0] = 1'b1;
        sys_rst = 1'b1;
        tick();
        chki("post_rst_fwd", int'(fwd[0]), 1);
        motor_direction[0] = 1'b0;
        ticks(3);
        sys_rst = 1'b0;
        #1;
        chk_all_zero("rst_dead");
        ticks(2);
        sys_rst = 1'b1;
        tick();
        chki("post_rst_rev", int'(rev[0]), 1);
        alarm_out_n[0] = 1'b0;
        run_window(60, 0, p, bad);
        chki("post_rst_retries", p, MAX_RETRY);
        chki("post_rst_lock", int'(fault[0]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
